// File: rtl/pspi_slave.sv
// PSPI responder: oversampled serial frame receive/transmit with even parity.
// Optional parity error counter built when PSPI_SLAVE_ERRCNT_EN is defined.
module pspi_slave #(
  parameter int                 DATA_W       = 7,
  parameter logic [DATA_W-1:0]  IDLE_PATTERN = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              sel,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              frame_abort,
  output logic [7:0]        err_cnt
);

  localparam int FRAME_W = DATA_W + 1;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  state_t state_q, state_d;

  logic [2:0]         sclk_sync_q, sclk_sync_d;
  logic [2:0]         sel_sync_q,  sel_sync_d;
  logic [1:0]         mosi_sync_q, mosi_sync_d;

  logic [FRAME_W-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_W-1:0] rx_shift_q, rx_shift_d;
  logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-1:0]  buf_q,      buf_d;
  logic               buf_full_q, buf_full_d;
  logic               miso_q,     miso_d;
  logic [DATA_W-1:0]  rx_data_q,  rx_data_d;
  logic               rx_err_q,   rx_err_d;
  logic               rx_valid_q, rx_valid_d;
  logic               abort_q,    abort_d;
  logic               under_q,    under_d;

  logic sclk_rise, sclk_fall, sel_rise, sel_lvl, mosi_s, frame_done;

  // Stages [1:0] resynchronise; stage [2] exists only for edge detection.
  assign sclk_sync_d = {sclk_sync_q[1:0], sclk};
  assign sel_sync_d  = {sel_sync_q[1:0],  sel};
  assign mosi_sync_d = {mosi_sync_q[0],   mosi};

  assign sclk_rise  =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign sel_rise   =  sel_sync_q[1]  & ~sel_sync_q[2];
  assign sel_lvl    =  sel_sync_q[1];
  assign mosi_s     =  mosi_sync_q[1];
  assign frame_done = (state_q == ST_SHIFT) && (bit_cnt_q == FRAME_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Completion wins over a late sel drop, keeping rx_valid and frame_abort exclusive.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (sel_rise) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (frame_done || !sel_lvl) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    under_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: miso_d = 1'b0;
      ST_LOAD: begin
        if (buf_full_q) begin
          tx_shift_d = {buf_q, ^buf_q};
        end else begin
          tx_shift_d = {IDLE_PATTERN, ^IDLE_PATTERN};
          under_d    = 1'b1;
        end
        miso_d     = tx_shift_d[FRAME_W-1];
        bit_cnt_d  = '0;
        rx_shift_d = '0;
      end
      ST_SHIFT: begin
        if (frame_done) begin
          rx_data_d  = rx_shift_q[FRAME_W-1:1];
          rx_err_d   = ^rx_shift_q;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
        end else if (!sel_lvl) begin
          abort_d = 1'b1;
          miso_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[FRAME_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end
          if (sclk_fall && (bit_cnt_q < FRAME_CNT)) begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[FRAME_W-2];
          end
        end
      end
      default: miso_d = 1'b0;
    endcase
  end

  // A load coinciding with LOAD on an empty buffer is kept for the following frame.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (state_q == ST_LOAD && buf_full_q) buf_full_d = 1'b0;
    if (tx_load && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      sel_sync_q  <= '0;
      mosi_sync_q <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_err_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sel_sync_q  <= sel_sync_d;
      mosi_sync_q <= mosi_sync_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_err_q    <= rx_err_d;
      rx_valid_q  <= rx_valid_d;
      abort_q     <= abort_d;
      under_q     <= under_d;
    end
  end

`ifdef PSPI_SLAVE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rx_valid_q && rx_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign miso        = miso_q;
  assign tx_ready    = ~buf_full_q;
  assign tx_underrun = under_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_err      = rx_err_q;
  assign frame_abort = abort_q;

endmodule
